image_mem_arbiter: RTL
======================

// Module: image_mem_arbiter
// PURPOSE
//  Shares the single-port image RAM between the UART address/data path (U) and the down-sampling
//  engine (D). Per-cycle req/gnt arbitration, round-robin or U-priority, optional lock for bursts.
//  Drives registered RAM controls and routes read data back to the requester that issued the read.
// PARAMETERS
//  ADDR_W   20  RAM address width
//  DATA_W    8  RAM data width
//  RD_LAT    2  RAM cycles from registered mem_en (read) to valid mem_rdata; range 1..4
//  U_PRIO    0  0 = round-robin; 1 = U always wins a contention (D starves while U requests)
// PORTS
//  clk        in   1       system clock
//  rst        in   1       synchronous reset, active-high
//  u_req      in   1       U access request; hold with u_we/u_addr/u_wdata stable until u_gnt
//  u_we       in   1       1 = write, 0 = read
//  u_lock     in   1       sampled with granted u_req: keep ownership for next U access
//  u_addr     in   ADDR_W  U address
//  u_wdata    in   DATA_W  U write data
//  u_gnt      out  1       combinational; access accepted this cycle
//  u_rvalid   out  1       one-cycle pulse, U read data valid
//  u_rdata    out  DATA_W  U read data, valid with u_rvalid
//  d_req/d_we/d_lock/d_addr/d_wdata/d_gnt/d_rvalid/d_rdata: same as U ports, for D
//  mem_en     out  1       registered RAM enable
//  mem_we     out  1       registered RAM write enable
//  mem_addr   out  ADDR_W  registered RAM address
//  mem_wdata  out  DATA_W  registered RAM write data
//  mem_rdata  in   DATA_W  RAM read data
//  busy       out  1       ownership held, or a read still in flight
// BEHAVIOUR
//  Reset: all outputs 0; u_gnt/d_gnt forced 0 while rst; FSM=IDLE; rr_last=D (U wins first tie).
//  FSM: IDLE, OWN_U, OWN_D.
//   IDLE: grant a sole requester; on contention grant per U_PRIO / rr_last.
//     Grant with lock=1 -> OWN_x, else stay IDLE.
//   OWN_x: only x can be granted; other gnt=0.
//     Granted x access with lock=0 -> IDLE. x not requesting -> stay OWN_x (lock persists).
//  At most one gnt per cycle. rr_last updates to the granted side on every grant.
//  Throughput: one access per cycle; a requester may present a new access the cycle after gnt.
//  Issue: grant in cycle t -> mem_en=1 with we/addr/wdata registered at edge t+1 (cycle t+1).
//    No grant -> mem_en=0, mem_we=0; addr/wdata hold their last values.
//  Read return: a 1-bit valid + 1-bit owner tag shifts through a RD_LAT+1 deep pipe.
//    The selected rvalid pulses in cycle t+1+RD_LAT. Its rdata is registered from mem_rdata
//    and holds until the next rvalid for that side. Writes produce no rvalid.
//  Ordering: read returns arrive in issue order; reads from U and D may interleave.
//  busy = (FSM!=IDLE) | any valid bit in the return pipe.
//  Reset mid-operation: pipe flushed (no rvalid after rst), lock released, FSM=IDLE, rdata=0.
//  Address is passed through unchanged; no range check (range checking belongs to the requesters).
// TESTING
//  1 U write bursts addr 0..3, data A0..A3, D idle -> u_gnt every cycle; mem_we=1 with addr 0..3
//    one cycle later; no rvalid.
//  2 U_PRIO=0, both read every cycle (U addr 0x10000, D addr 0x00005) -> gnt alternates U,D,U,D;
//    each rvalid exactly 1+RD_LAT cycles after its gnt with the matching data.
//  3 D asserts lock for 3 writes while U requests -> u_gnt=0 until D's unlocked access is granted;
//    U granted the following cycle; busy=1 throughout.
//  4 U_PRIO=1, both request continuously for 8 cycles -> u_gnt all 8 cycles, d_gnt=0;
//    D granted the first cycle U drops req.
//  5 rst asserted one cycle after a D read grant with RD_LAT=2 -> no d_rvalid; all outputs 0;
//    the first post-reset tie goes to U.
//  6 Single read at addr 0x13FFF with RD_LAT=1,3,4 -> rvalid at t+2, t+4, t+5 respectively;
//    no duplicate or missing pulse.

Source files
------------

// File: rtl/image_mem_arbiter_if.sv
// Requester-side bus of the image RAM arbiter: one access request with its
// grant and the read-return path back to that requester.
interface image_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 8
);
  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  // Requester drives the access, arbiter answers with grant and read data.
  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/image_mem_arbiter.sv
// Shares the single-port image RAM between the UART path (U) and the
// down-sampling engine (D). Grants are combinational, RAM controls are
// registered, and read data is steered back using a tag that travels with
// each read through a fixed-latency return pipe.
module image_mem_arbiter #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned U_PRIO = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  image_mem_arbiter_if.slave        u_bus,
  image_mem_arbiter_if.slave        d_bus,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy
);

  typedef enum logic [1:0] {StIdle, StOwnU, StOwnD} state_e;

  state_e            state_q, state_d;
  logic              last_d_q, last_d_d;   // 1: most recent grant went to D
  logic              gnt_u, gnt_d;

  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Return pipe: stage 0 lines up with the registered mem_en of the read,
  // stage RD_LAT with the cycle its data is on mem_rdata. Tag 1 = D.
  logic [RD_LAT:0]   pipe_v_q, pipe_v_d;
  logic [RD_LAT:0]   pipe_tag_q, pipe_tag_d;
  logic              ret_v;

  logic [DATA_W-1:0] u_rdata_q, u_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  // Arbitration: at most one grant, restricted to the owner while locked.
  always_comb begin
    gnt_u = 1'b0;
    gnt_d = 1'b0;
    if (!rst) begin
      case (state_q)
        StOwnU:  gnt_u = u_bus.req;
        StOwnD:  gnt_d = d_bus.req;
        default: begin
          if (u_bus.req && d_bus.req) begin
            // U wins a tie under fixed priority, or when D had the last turn.
            if ((U_PRIO != 0) || last_d_q) gnt_u = 1'b1;
            else                           gnt_d = 1'b1;
          end else begin
            gnt_u = u_bus.req;
            gnt_d = d_bus.req;
          end
        end
      endcase
    end
  end

  assign u_bus.gnt = gnt_u;
  assign d_bus.gnt = gnt_d;

  // Ownership and round-robin history follow every grant.
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    if (gnt_u) begin
      state_d  = u_bus.lock ? StOwnU : StIdle;
      last_d_d = 1'b0;
    end else if (gnt_d) begin
      state_d  = d_bus.lock ? StOwnD : StIdle;
      last_d_d = 1'b1;
    end
  end

  // RAM issue: address and write data hold their last values when idle.
  always_comb begin
    mem_en_d    = gnt_u | gnt_d;
    mem_we_d    = (gnt_u & u_bus.we) | (gnt_d & d_bus.we);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (gnt_u) begin
      mem_addr_d  = u_bus.addr;
      mem_wdata_d = u_bus.wdata;
    end else if (gnt_d) begin
      mem_addr_d  = d_bus.addr;
      mem_wdata_d = d_bus.wdata;
    end
    pipe_v_d   = {pipe_v_q[RD_LAT-1:0], mem_en_d & ~mem_we_d};
    pipe_tag_d = {pipe_tag_q[RD_LAT-1:0], gnt_d};
  end

  assign ret_v        = pipe_v_q[RD_LAT] & ~rst;
  assign u_bus.rvalid = ret_v & ~pipe_tag_q[RD_LAT];
  assign d_bus.rvalid = ret_v & pipe_tag_q[RD_LAT];

  // Read data is forwarded in its return cycle and held afterwards.
  always_comb begin
    u_rdata_d = u_bus.rvalid ? mem_rdata : u_rdata_q;
    d_rdata_d = d_bus.rvalid ? mem_rdata : d_rdata_q;
  end

  assign u_bus.rdata = u_rdata_d;
  assign d_bus.rdata = d_rdata_d;

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != StIdle) | (|pipe_v_q);

  // State registers; reset flushes the return pipe and releases any lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_d_q    <= 1'b1;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pipe_v_q    <= '0;
      pipe_tag_q  <= '0;
      u_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pipe_v_q    <= pipe_v_d;
      pipe_tag_q  <= pipe_tag_d;
      u_rdata_q   <= u_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

endmodule
